// File: rtl/mem_access_unit.sv
// Load/store engine between the control FSM and a single-port word RAM without
// byte enables. One request at a time. Sub-word stores use read-modify-write.
// Loads return sign- or zero-extended data through a valid/ready response.
module mem_access_unit #(
  parameter int unsigned RAM_AW     = 12,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StResp} state_e;

  // Value of the wait counter in the last RD_WAIT cycle.
  localparam logic [1:0] LastWait = 2'(RAM_RD_LAT - 1);

  state_e            state_q;
  logic [RAM_AW+1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ram_wdata_q;
  logic [1:0]        wait_q;

  logic              f3_legal;
  logic              misaligned;
  logic              req_bad;
  logic              is_sw;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic [31:0]       store_merge;

  // Address bits above the RAM window wrap silently.
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:RAM_AW+2];

  // Legality and alignment of the incoming request.
  always_comb begin
    if (req_we_i) begin
      f3_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    case (req_funct3_i[1:0])
      2'b01:   misaligned = req_addr_i[0];
      2'b10:   misaligned = |req_addr_i[1:0];
      default: misaligned = 1'b0;
    endcase
    req_bad = !f3_legal || misaligned;
    is_sw   = req_we_i && (req_funct3_i == 3'b010);
  end

  // Lane selection, load extension and sub-word store merge on the RAM read word.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00: rd_byte = ram_rdata_i[7:0];
      2'b01: rd_byte = ram_rdata_i[15:8];
      2'b10: rd_byte = ram_rdata_i[23:16];
      2'b11: rd_byte = ram_rdata_i[31:24];
    endcase
    rd_half = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];

    case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = ram_rdata_i;
    endcase

    store_merge = ram_rdata_i;
    if (funct3_q[0]) begin
      if (addr_q[1]) store_merge[31:16] = wdata_q;
      else           store_merge[15:0]  = wdata_q;
    end else begin
      unique case (addr_q[1:0])
        2'b00: store_merge[7:0]   = wdata_q[7:0];
        2'b01: store_merge[15:8]  = wdata_q[7:0];
        2'b10: store_merge[23:16] = wdata_q[7:0];
        2'b11: store_merge[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Control FSM with captured request and registered response/write data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ram_wdata_q <= '0;
      wait_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i[RAM_AW+1:0];
            funct3_q    <= req_funct3_i;
            we_q        <= req_we_i;
            wdata_q     <= req_wdata_i[15:0];
            err_q       <= req_bad;
            rdata_q     <= '0;
            // A full-word store needs no read, so its write data is ready now.
            ram_wdata_q <= req_wdata_i;
            if (req_bad) begin
              state_q <= StResp;
            end else if (is_sw) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          wait_q  <= '0;
          state_q <= StRdWait;
        end
        StRdWait: begin
          if (wait_q == LastWait) begin
            if (we_q) begin
              ram_wdata_q <= store_merge;
              state_q     <= StWr;
            end else begin
              rdata_q <= load_ext;
              state_q <= StResp;
            end
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        StWr: begin
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and RAM strobes are pure state decodes so reset kills them at once.
  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign ram_en_o    = (state_q == StRd) || (state_q == StWr);
  assign ram_we_o    = (state_q == StWr);
  assign ram_addr_o  = addr_q[RAM_AW+1:2];
  assign ram_wdata_o = ram_wdata_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3), each with a
// behavioural RAM, directed steps followed by randomized transactions.
module tb_mem_access_unit;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, ram_en, ram_we;
  logic [2:0]    req_f3 [2];
  logic [31:0]   req_addr [2];
  logic [31:0]   req_wdata [2];
  logic [31:0]   rsp_rdata [2];
  logic [31:0]   ram_wdata [2];
  logic [31:0]   ram_rdata [2];
  logic [AW-1:0] ram_addr [2];

  logic [31:0]   mem0 [4096];
  logic [31:0]   mem1 [4096];
  logic [31:0]   s1, s2;
  logic [1:0]    tb_we;
  logic [AW-1:0] tb_wa;
  logic [31:0]   tb_wv [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_AW(AW), .RAM_RD_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_funct3_i(req_f3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .ram_en_o(ram_en[0]), .ram_we_o(ram_we[0]),
    .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0])
  );

  mem_access_unit #(.RAM_AW(AW), .RAM_RD_LAT(3)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_funct3_i(req_f3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .ram_en_o(ram_en[1]), .ram_we_o(ram_we[1]),
    .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1])
  );

  // Latency-1 RAM; the bench loads it through its own write port.
  always @(posedge clk) begin
    if (tb_we[0]) mem0[tb_wa] <= tb_wv[0];
    else if (ram_en[0]) begin
      if (ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
      else ram_rdata[0] <= mem0[ram_addr[0]];
    end
  end

  // Latency-3 RAM: read word passes through two extra pipeline stages.
  always @(posedge clk) begin
    if (tb_we[1]) mem1[tb_wa] <= tb_wv[1];
    else if (ram_en[1]) begin
      if (ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
      else s1 <= mem1[ram_addr[1]];
    end
    s2 <= s1;
    ram_rdata[1] <= s2;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int k, input logic [AW-1:0] a);
    return (k == 0) ? mem0[a] : mem1[a];
  endfunction

  task automatic mem_wr(input int k, input logic [AW-1:0] a, input logic [31:0] v);
    tb_wa = a;
    tb_wv[k] = v;
    tb_we[k] = 1'b1;
    @(posedge clk);
    #1;
    tb_we = 2'b00;
  endtask

  // Expected response and resulting RAM word, computed from byte arithmetic.
  function automatic void ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [31:0] old,
                                    output logic err, output logic [31:0] rd,
                                    output logic [31:0] nw);
    int unsigned size, shift;
    longint unsigned mask, v;
    bit legal;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size  = 32'd1 << f3[1:0];
    shift = (addr % 32'd4) * 8;
    err   = !legal || ((addr % size) != 0);
    mask  = (64'd1 << (8 * size)) - 64'd1;
    v     = ({32'd0, old} >> shift) & mask;
    if (!f3[2] && size < 4 && v >= (mask + 64'd1) / 2) v = v | ~mask;
    rd = (err || we) ? 32'd0 : v[31:0];
    v  = ({32'd0, old} & ~(mask << shift)) | (({32'd0, wd} & mask) << shift);
    nw = (err || !we) ? old : v[31:0];
  endfunction

  // One request on instance k; hold = cycles rsp_ready stays low after rsp_valid.
  task automatic txn(input int k, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, output logic [31:0] got);
    int lat, cyc, en_cnt, we_cnt, wr_cyc, exp_cyc, exp_en, exp_wcyc;
    logic [AW-1:0] wa;
    logic [31:0] old, exp_rd, exp_word, wr_data, held;
    logic exp_err, seen, is_st;
    lat = (k == 0) ? 1 : 3;
    wa  = addr[AW+1:2];
    old = mem_rd(k, wa);
    ref_model(we, f3, addr, wd, old, exp_err, exp_rd, exp_word);
    is_st = we && !exp_err;
    exp_wcyc = 0;
    if (exp_err) begin
      exp_cyc = 1; exp_en = 0;
    end else if (we && f3 == 3'd2) begin
      exp_cyc = 2; exp_en = 1; exp_wcyc = 1;
    end else if (we) begin
      exp_cyc = lat + 3; exp_en = 2; exp_wcyc = lat + 2;
    end else begin
      exp_cyc = lat + 2; exp_en = 1;
    end
    chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_we[k] = we; req_f3[k] = f3; req_addr[k] = addr; req_wdata[k] = wd; req_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    en_cnt = 0; we_cnt = 0; wr_cyc = 0; wr_data = '0; seen = 1'b0; cyc = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ram_en[k]) begin
        en_cnt++;
        chk("ram_addr", 32'(ram_addr[k]), 32'(wa));
      end
      if (ram_we[k]) begin
        we_cnt++; wr_cyc = cyc; wr_data = ram_wdata[k];
      end
      seen = rsp_valid[k];
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("rsp_latency", cyc, exp_cyc);
    chk("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
    chk("rsp_rdata", rsp_rdata[k], exp_rd);
    chk("ram_en_pulses", en_cnt, exp_en);
    chk("ram_we_pulses", we_cnt, is_st ? 32'd1 : 32'd0);
    if (is_st) begin
      chk("wr_cycle", wr_cyc, exp_wcyc);
      chk("wr_data", wr_data, exp_word);
    end
    got  = rsp_rdata[k];
    held = got;
    for (int h = 0; h < hold; h++) begin
      // A competing request while the response is pending must be ignored.
      req_valid[k] = 1'b1; req_we[k] = 1'b0; req_f3[k] = 3'd2; req_addr[k] = addr ^ 32'h10;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold_rdata", rsp_rdata[k], held);
      chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
      chk("hold_ram_en", 32'(ram_en[k]), 32'd0);
    end
    if (hold == 0) req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    chk("post_req_ready", 32'(req_ready[k]), 32'd1);
    chk("post_ram_en", 32'(ram_en[k]), 32'd0);
    req_valid[k] = 1'b0;
    if (is_st) chk("mem_word", mem_rd(k, wa), exp_word);
  endtask

  // SB on the latency-3 instance, reset asserted nneg cycles after accept.
  task automatic reset_mid(input int nneg, input logic [31:0] addr, input logic pre_we);
    logic [AW-1:0] wa;
    logic [31:0] old;
    wa = addr[AW+1:2];
    mem_wr(1, wa, 32'h01020304);
    old = mem_rd(1, wa);
    req_we[1] = 1'b1; req_f3[1] = 3'd0; req_addr[1] = addr; req_wdata[1] = 32'h5A;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (nneg) @(negedge clk);
    chk("rst_pre_we", 32'(ram_we[1]), 32'(pre_we));
    rst_n = 1'b0;
    #1;
    chk("rst_ram_en", 32'(ram_en[1]), 32'd0);
    chk("rst_ram_we", 32'(ram_we[1]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_ram_wdata", ram_wdata[1], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_rel_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_mem_same", mem_rd(1, wa), old);
  endtask

  initial begin
    logic [31:0] got, addr;
    logic [2:0] f3;
    logic we;
    req_valid = '0; req_we = '0; rsp_ready = '0; tb_we = '0;
    for (int k = 0; k < 2; k++) begin
      req_f3[k] = '0; req_addr[k] = '0; req_wdata[k] = '0; tb_wv[k] = '0;
    end
    tb_wa = '0;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", 32'(req_ready[k]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[k], 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
      chk("reset_ram_en", 32'(ram_en[k]), 32'd0);
      chk("reset_ram_we", 32'(ram_we[k]), 32'd0);
      chk("reset_ram_addr", 32'(ram_addr[k]), 32'd0);
      chk("reset_ram_wdata", ram_wdata[k], 32'd0);
    end
    // Fill both RAMs with random words while reset is held.
    for (int i = 0; i < 4096; i++) begin
      tb_wa = AW'(i); tb_wv[0] = $urandom; tb_wv[1] = $urandom; tb_we = 2'b11;
      @(posedge clk);
      #1;
    end
    tb_we = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads with lane select and extension.
    mem_wr(0, 12'h010, 32'h80FF1234);
    txn(0, 1'b0, 3'b000, 32'h43, 32'h0, 0, got); chk("plan_lb", got, 32'hFFFFFF80);
    txn(0, 1'b0, 3'b100, 32'h43, 32'h0, 0, got); chk("plan_lbu", got, 32'h00000080);
    txn(0, 1'b0, 3'b001, 32'h42, 32'h0, 0, got); chk("plan_lh", got, 32'hFFFF80FF);
    txn(0, 1'b0, 3'b101, 32'h42, 32'h0, 0, got); chk("plan_lhu", got, 32'h000080FF);

    // Full-word store.
    txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, got);
    chk("plan_sw_rdata", got, 32'h0);
    chk("plan_sw_mem", mem_rd(0, 12'h004), 32'hDEADBEEF);

    // Read-modify-write byte and halfword stores.
    mem_wr(0, 12'h010, 32'h11223344);
    txn(0, 1'b1, 3'b000, 32'h41, 32'h000000AA, 0, got);
    chk("plan_sb_mem", mem_rd(0, 12'h010), 32'h1122AA44);
    txn(0, 1'b1, 3'b001, 32'h42, 32'h0000BEEF, 0, got);
    chk("plan_sh_mem", mem_rd(0, 12'h010), 32'hBEEFAA44);

    // Errors: misaligned word load, illegal load funct3, illegal store funct3.
    txn(0, 1'b0, 3'b010, 32'h42, 32'h0, 0, got); chk("plan_mis_rdata", got, 32'h0);
    txn(0, 1'b0, 3'b011, 32'h40, 32'h0, 0, got); chk("plan_ill_rdata", got, 32'h0);
    txn(1, 1'b1, 3'b100, 32'h40, 32'h0, 0, got);

    // Back-pressure on the response.
    txn(0, 1'b0, 3'b010, 32'h40, 32'h0, 5, got); chk("plan_hold_lw", got, 32'hBEEFAA44);

    // Latency-3 instance: word load, sub-word store, address wrap.
    mem_wr(1, 12'h020, 32'hCAFEF00D);
    txn(1, 1'b0, 3'b010, 32'h80, 32'h0, 0, got); chk("plan_lat3_lw", got, 32'hCAFEF00D);
    txn(1, 1'b1, 3'b001, 32'h82, 32'h00001234, 1, got);
    chk("plan_lat3_sh", mem_rd(1, 12'h020), 32'h1234F00D);
    txn(1, 1'b0, 3'b000, 32'hFFFF_C081, 32'h0, 0, got); chk("plan_wrap_lb", got, 32'hFFFFFFF0);

    // Reset during the read wait and during the write cycle of an SB.
    reset_mid(3, 32'h45, 1'b0);
    reset_mid(5, 32'h46, 1'b1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 48; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if (f3[1:0] == 2'd2 && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if (f3[1:0] == 2'd1 && $urandom_range(0, 3) != 0) addr[0] = 1'b0;
      txn(i % 2, we, f3, addr, $urandom, int'($urandom_range(0, 2)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store engine between the multicycle control FSM/datapath and a single-port synchronous word RAM that has no byte enables.
- Accepts one memory request at a time and issues the RAM read/write cycles itself.
- Performs read-modify-write for SB/SH and sign/zero extension for loads.
- Returns a single response with data or an error, so the control FSM only waits on a valid/ready handshake.

Parameters:
- RAM_AW, 12, RAM word-address width; RAM depth is 2^RAM_AW 32-bit words.
- RAM_RD_LAT, 1, RAM read latency in cycles; legal values are 1..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 of the load/store.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, taken from the low bytes.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned access or illegal funct3.
- ram_en  output  1  RAM access strobe.
- ram_we  output  1  RAM write strobe; only asserted together with ram_en.
- ram_addr  output  RAM_AW  word address, equal to addr[RAM_AW+1:2].
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data, valid RAM_RD_LAT cycles after the ram_en read cycle.

Behaviour:
- States: IDLE, RD, RD_WAIT, WR, RESP.
- req_ready = (state == IDLE), decoded combinationally from the state register. ram_en and ram_we are also state decodes.
- Reset (rst = 0), asynchronous:
  - state = IDLE; all captured registers cleared.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Reset mid-operation: the in-flight request is discarded. No RAM write completes after reset asserts; ram_we drops asynchronously.
- Accept: on a clock edge with req_valid && req_ready, latch addr, funct3, wdata and we. Call the accept cycle A.
- Legality check, done at accept:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal or misaligned: go to RESP with rsp_err = 1 and rsp_rdata = 0. No RAM cycle is issued.
- Load path: IDLE → RD (cycle A+1: ram_en = 1, ram_we = 0) → RD_WAIT for RAM_RD_LAT cycles.
  - ram_rdata is sampled at the end of the last RD_WAIT cycle, extended, and registered.
  - Next state is RESP, so rsp_valid rises in cycle A+2+RAM_RD_LAT.
- Load extension, lane select:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- SW path: IDLE → WR (cycle A+1: ram_en = 1, ram_we = 1, ram_wdata = wdata) → RESP in A+2.
- SB/SH path: RD → RD_WAIT (same as load) → WR → RESP.
  - In WR, ram_wdata is the read word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - Write occurs in cycle A+2+RAM_RD_LAT; rsp_valid rises in A+3+RAM_RD_LAT.
- ram_addr is held constant from RD through WR.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the edge where rsp_valid && rsp_ready, return to IDLE. The next request can be accepted one cycle later; there is no same-cycle turnaround.
- Address bits above RAM_AW+1 are ignored, so accesses wrap modulo the RAM size. No error is raised for them.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Test Plan:
1. RAM_RD_LAT=1, word 0x40 = 0x80FF1234. LB 0x43 → rsp_rdata 0xFFFFFF80. LBU 0x43 → 0x00000080. LH 0x42 → 0xFFFF80FF. Each rsp_valid in cycle A+3, rsp_err = 0, exactly one ram_en pulse with ram_addr = 0x10.
2. SW addr 0x10 data 0xDEADBEEF → one cycle ram_en = ram_we = 1 at A+1, ram_addr = 4, ram_wdata = 0xDEADBEEF; rsp_valid at A+2, rsp_rdata = 0.
3. Word 0x40 = 0x11223344. SB 0x41 data 0x000000AA → read at A+1, write 0x1122AA44 at A+3. Then SH 0x42 data 0xBEEF → 0xBEEFAA44.
4. Misaligned LW 0x42, and load funct3 = 011 → rsp_err = 1, rsp_rdata = 0, no ram_en pulse, rsp_valid at A+1.
5. rsp_ready held low 5 cycles on a load → rsp_valid/rsp_rdata stable, req_ready = 0, a second req_valid is not accepted; after release, next accept no earlier than one cycle later.
6. RAM_RD_LAT=3: LW latency = 5 cycles. Assert rst during RD_WAIT of an SB → ram_en/ram_we low immediately, rsp_valid = 0, RAM contents unchanged, req_ready = 1 after release.
